// File: rtl/seg7_pkg.sv
// Shared types and constants for the three-digit scanned seven-segment display:
// converter FSM states, active-low digit patterns and the double-dabble step.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } b2b_state_t;

    localparam int BIN_W = 8;
    localparam int BCD_W = 12;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
    localparam logic [7:0] SEG_PAT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // One double-dabble iteration on {hundreds, tens, ones, binary}.
    function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W+BIN_W-1:0] s);
        logic [BCD_W+BIN_W-1:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[BIN_W+4*i +: 4] >= 4'd5)
                a[BIN_W+4*i +: 4] = a[BIN_W+4*i +: 4] + 4'd3;
        end
        return {a[BCD_W+BIN_W-2:0], 1'b0};
    endfunction

    // Non-decimal nibbles fall back to a dark digit.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] r;
        r = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            if (d == 4'(k))
                r = SEG_PAT[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display-side bundle: binary count in, scanned segment/anode drive and busy out.
interface seg7_scan_display_if;
    logic [7:0] value;
    logic [7:0] seg;
    logic [2:0] an;
    logic       busy;

    modport master (output value, input seg, an, busy);
    modport slave  (input value, output seg, an, busy);
endinterface

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clk).
// state     | meaning
// ST_IDLE   | waiting for start; loads bin into the shift register on start
// ST_SHIFT  | eight add-3/shift iterations, one per clk
// ST_COMMIT | result stable on bcd, done pulses for the consumer to capture
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    b2b_state_t                 state_q, state_d;
    logic [BCD_W+BIN_W-1:0]     shreg_q;
    logic [2:0]                 iter_q;
    logic                       load, step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SHIFT;
            ST_SHIFT:  if (iter_q == 3'd0) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_IDLE:   load = start;
            ST_SHIFT:  begin step = 1'b1; busy = 1'b1; end
            ST_COMMIT: begin done = 1'b1; busy = 1'b1; end
            default:   ;
        endcase
    end

    // Iteration timer counts down 7..0; the iteration taken at 0 is the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            iter_q  <= 3'd0;
        end else if (load) begin
            shreg_q <= {{BCD_W{1'b0}}, bin};
            iter_q  <= 3'd7;
        end else if (step) begin
            shreg_q <= dd_step(shreg_q);
            iter_q  <= iter_q - 3'd1;
        end
    end

    assign bcd = shreg_q[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/seg7_scan_display.sv
// Three-digit multiplexed seven-segment driver fed by a binary count.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_display_if.slave   disp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    logic [BIN_W-1:0] sample_q;
    logic             first_q;
    logic             start, b2b_busy, b2b_done;
    logic [BCD_W-1:0] b2b_bcd, bcd_disp_q;
    logic [PW-1:0]    presc_q;
    logic [1:0]       dig_q;
    logic [3:0]       nib;
    logic             blank;
    logic [7:0]       seg_d, seg_q;
    logic [2:0]       an_d, an_q;

    // first_q forces one conversion after reset even when value equals the cleared sample.
    assign start = first_q | (disp.value != sample_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            first_q  <= 1'b1;
        end else if (start && !b2b_busy) begin
            sample_q <= disp.value;
            first_q  <= 1'b0;
        end
    end

    bin2bcd_seq u_b2b (
        .clk   (clk),
        .rst   (rst),
        .bin   (disp.value),
        .start (start),
        .busy  (b2b_busy),
        .bcd   (b2b_bcd),
        .done  (b2b_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           bcd_disp_q <= '0;
        else if (b2b_done) bcd_disp_q <= b2b_bcd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            dig_q   <= 2'd0;
        end else if (presc_q == PRESC_TC) begin
            presc_q <= '0;
            dig_q   <= (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        case (dig_q)
            2'd0:    begin nib = bcd_disp_q[3:0];  an_d = 3'b110; end
            2'd1:    begin nib = bcd_disp_q[7:4];  an_d = 3'b101; end
            default: begin nib = bcd_disp_q[11:8]; an_d = 3'b011; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((dig_q == 2'd2) && (bcd_disp_q[11:8] == 4'd0)) ||
                ((dig_q == 2'd1) && (bcd_disp_q[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
        seg_d = blank ? 8'hFF : seg_encode(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 8'hFF;
            an_q  <= 3'b111;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign disp.seg  = seg_q;
    assign disp.an   = an_q;
    assign disp.busy = b2b_busy;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV = 4; expectations are hand-computed.
module tb_seg7_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    typedef struct {
        logic [7:0]  v;
        logic [11:0] bcd;
        logic [7:0]  o, t, h;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_display_if bus ();

    seg7_scan_display #(.SCAN_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [6];
    logic [2:0] pat [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic grab(output logic [7:0] o, output logic [7:0] t, output logic [7:0] h);
        o = 8'h00; t = 8'h00; h = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            case (bus.an)
                3'b110:  o = bus.seg;
                3'b101:  t = bus.seg;
                3'b011:  h = bus.seg;
                default: ;
            endcase
        end
    endtask

    task automatic check_digits(input int idx, input string tag);
        logic [7:0] o, t, h;
        grab(o, t, h);
        chk({tag, "_ones"}, o, vecs[idx].o);
        chk({tag, "_tens"}, t, vecs[idx].t);
        chk({tag, "_hund"}, h, vecs[idx].h);
    endtask

    task automatic wait_bcd(input logic [11:0] exp, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (dut.bcd_disp_q == exp) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] prev, cur, first_new, second_new;
        int          changes;
        logic [2:0]  prev_an;
        bit          aligned, saw_busy;

        vecs[0] = '{8'd0,   12'h000, 8'hC0, Z,     Z};
        vecs[1] = '{8'd255, 12'h255, 8'h92, 8'h92, 8'hA4};
        vecs[2] = '{8'd42,  12'h042, 8'hA4, 8'h99, Z};
        vecs[3] = '{8'd7,   12'h007, 8'hF8, Z,     Z};
        vecs[4] = '{8'd100, 12'h100, 8'hC0, 8'hC0, 8'hF9};
        vecs[5] = '{8'd200, 12'h200, 8'hC0, 8'hC0, 8'hA4};
        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

        bus.value = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_seg",  bus.seg,  8'hFF);
        chk("rst_an",   bus.an,   3'b111);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_bcd",  dut.bcd_disp_q, 12'h000);

        rst = 1'b0;
        @(negedge clk);
        chk("first_conv_busy", bus.busy, 1'b1);
        for (int i = 0; i < 12 && bus.busy; i++) @(negedge clk);
        chk("first_conv_idle", bus.busy, 1'b0);
        chk("zero_bcd", dut.bcd_disp_q, 12'h000);
        check_digits(0, "zero");

        for (int k = 1; k <= 3; k++) begin
            bus.value = vecs[k].v;
            wait_bcd(vecs[k].bcd, 11);
            chk($sformatf("bcd_v%0d", vecs[k].v), dut.bcd_disp_q, vecs[k].bcd);
            check_digits(k, $sformatf("v%0d", vecs[k].v));
        end

        // 100 then 42 mid-conversion: display must step 007 -> 100 -> 042 only.
        bus.value = 8'd100;
        prev = dut.bcd_disp_q;
        first_new = 12'hFFF; second_new = 12'hFFF; changes = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            cur = dut.bcd_disp_q;
            if (cur != prev) begin
                changes++;
                if (changes == 1) first_new = cur;
                if (changes == 2) second_new = cur;
                prev = cur;
            end
            if (i == 3) bus.value = 8'd42;
        end
        chk("seq_first",   first_new,  12'h100);
        chk("seq_second",  second_new, 12'h042);
        chk("seq_changes", changes,    2);
        check_digits(2, "seq42");

        prev_an = bus.an; aligned = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.an == 3'b110 && prev_an != 3'b110) begin aligned = 1'b1; break; end
            prev_an = bus.an;
        end
        chk("scan_align", aligned, 1'b1);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("scan_an_%0d", i), bus.an, pat[(i / 4) % 3]);
            @(negedge clk);
        end

        bus.value = 8'd200;
        repeat (3) @(negedge clk);
        chk("mid_shift_busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg",  bus.seg,  8'hFF);
        chk("arst_an",   bus.an,   3'b111);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_bcd",  dut.bcd_disp_q, 12'h000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy) saw_busy = 1'b1;
            if (dut.bcd_disp_q == 12'h200) break;
        end
        chk("post_rst_busy", saw_busy, 1'b1);
        chk("post_rst_bcd",  dut.bcd_disp_q, 12'h200);
        check_digits(5, "v200");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit is held lit; legal range >= 2.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port value, input, 8, unsigned binary count from the upstream obstacle counter stage.
REQ-005 SHALL have port seg, output, 8, active-low segments: bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
REQ-006 SHALL have port an, output, 3, active-low digit enables: an[0] = ones, an[1] = tens, an[2] = hundreds.
REQ-007 SHALL have port busy, output, 1, high while a binary-to-BCD conversion is in progress.

Function
REQ-008 SHALL hold a sample register and a 12-bit display BCD register (hundreds, tens, ones).
REQ-009 SHALL run a conversion FSM with states IDLE, SHIFT and COMMIT.
- IDLE: if value differs from the sample register, or this is the first IDLE cycle after reset, latch value and go to SHIFT.
REQ-010 SHALL use sequential double-dabble in SHIFT: 8 iterations, one per clk; add 3 to any BCD nibble >= 5, then shift left 1.
REQ-011 SHALL copy the result atomically into the display BCD register in COMMIT, then return to IDLE.
- Latency from value change to updated display register: <= 11 clk.
REQ-012 SHALL ignore value while in SHIFT or COMMIT; a change during conversion is detected in the next IDLE and triggers a new conversion.
REQ-013 SHALL drive busy high in SHIFT and COMMIT, low in IDLE.
REQ-014 SHALL make the display BCD register hold only committed results, never intermediate shift data.
REQ-015 SHALL count a scan prescaler 0..SCAN_DIV-1 with width $clog2(SCAN_DIV); at terminal count it wraps to 0 and the digit index advances 0 -> 1 -> 2 -> 0.
REQ-016 SHALL register seg and an every clk from the current digit index and display BCD register; exactly one an bit is low at a time after the first post-reset cycle.
REQ-017 SHALL keep seg[7] (dp) at 1.
REQ-018 SHALL encode digits 0-9 active-low, e.g. 0 = 0xC0, 2 = 0xA4, 5 = 0x92, 7 = 0xF8; nibble values above 9 SHALL NOT occur.

Reset
REQ-019 SHALL, on rst high, immediately set:
- seg = 0xFF, an = 3'b111, busy = 0
- FSM = IDLE, sample = 0, display BCD = 0
- prescaler = 0, digit index = 0
REQ-020 SHALL abort any conversion in progress on rst without committing it, and convert the current value after rst is released (REQ-009).

Configuration
REQ-021 SHALL, with macro LEADING_ZERO_BLANK_EN defined:
- force seg = 0xFF for the hundreds digit when it is 0
- force seg = 0xFF for the tens digit when hundreds and tens are both 0
- never blank the ones digit
- keep an scanning unchanged
REQ-022 SHALL, without LEADING_ZERO_BLANK_EN, display all three digits including leading zeros.

Structure
REQ-023 SHALL place the FSM state typedef and the 10-entry seven-segment pattern constant table in shared package seg7_pkg.
REQ-024 SHALL implement the double-dabble datapath and FSM in sub-module bin2bcd_seq (ports clk, rst, bin, start, busy, bcd, done); scan and segment logic stay in the top level.

Verification
REQ-025 Reset then value = 0, SCAN_DIV = 4:
- ones shows 0xC0
- tens/hundreds show 0xFF with LEADING_ZERO_BLANK_EN, 0xC0 without
REQ-026 value = 255: within 11 clk the display BCD = 2,5,5; scanned seg = ones 0x92, tens 0x92, hundreds 0xA4.
REQ-027 value = 7 with LEADING_ZERO_BLANK_EN: hundreds 0xFF, tens 0xFF, ones 0xF8.
REQ-028 value = 100, then 42 three clk after conversion start:
- display BCD first commits 1,0,0, then 0,4,2 within 22 clk total
- no other value ever appears in the display register
REQ-029 SCAN_DIV = 4, free-running: an follows 110, 101, 011, 110 ..., each held exactly 4 clk.
REQ-030 Assert rst mid-SHIFT while value = 200:
- outputs go to reset values in the same cycle
- after release, busy pulses and display shows 2,0,0 within 12 clk
